// File: rtl/pattern_fsm.sv
// Pattern detector: compares the last LEN accepted W-bit symbols against PATTERN,
// with a registered match pulse, a "one symbol from match" flag and a saturating match count.
module pattern_fsm #(
    parameter int unsigned      W       = 2,
    parameter int unsigned      LEN     = 4,
    parameter logic [W*LEN-1:0] PATTERN = 8'b10_11_01_10,
    parameter bit               OVERLAP = 1'b1,
    parameter int unsigned      CW      = 4
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          en,
    input  logic          clr,
    input  logic [W-1:0]  sym,
    output logic          m,
    output logic          n,
    output logic [CW-1:0] cnt
);

    localparam int unsigned HW     = W * LEN;
    localparam int unsigned HEAD_W = W * (LEN - 1);
    localparam int unsigned FW     = $clog2(LEN + 1);

    localparam logic [FW-1:0]     FILL_FULL = FW'(LEN);
    localparam logic [FW-1:0]     FILL_NEAR = FW'(LEN - 1);
    localparam logic [HEAD_W-1:0] PAT_HEAD  = PATTERN[HW-1:W];

    logic [HW-1:0] hist_q, hist_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          m_q, m_d;
    logic          n_q, n_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Candidate history/fill if the current symbol is accepted
    logic [HW-1:0] hist_acc_c;
    logic [FW-1:0] fill_acc_c;
    logic          match_c;

    assign hist_acc_c = {hist_q[HEAD_W-1:0], sym};
    assign fill_acc_c = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
    assign match_c    = (fill_acc_c == FILL_FULL) && (hist_acc_c == PATTERN);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        m_d    = 1'b0;
        n_d    = n_q;
        cnt_d  = cnt_q;

        if (clr) begin
            hist_d = '0;
            fill_d = '0;
            n_d    = 1'b0;
            cnt_d  = '0;
        end else if (en) begin
            m_d = match_c;
            if (match_c && (cnt_q != {CW{1'b1}})) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (match_c && !OVERLAP) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_acc_c;
                fill_d = fill_acc_c;
            end
            // n looks at the history being written, so a discarded match leaves it low
            n_d = (fill_d >= FILL_NEAR) && (hist_d[HEAD_W-1:0] == PAT_HEAD);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hist_q <= '0;
            fill_q <= '0;
            m_q    <= 1'b0;
            n_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            m_q    <= m_d;
            n_q    <= n_d;
            cnt_q  <= cnt_d;
        end
    end

    assign m   = m_q;
    assign n   = n_q;
    assign cnt = cnt_q;

endmodule
